// File: rtl/timed_step_seq.sv
// Timed step sequencer: runs (steps+1) steps of len clocks each and fires a strobe at a fixed tick in every step.
// Strobe and done are registered one clock after the cycle that triggers them. stop aborts a run on the next edge.
module timed_step_seq #(
  parameter int W            = 8,
  parameter int IDX_W        = 2,
  parameter int TRIG_AT      = 0,
  parameter int AUTO_RESTART = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [W-1:0]     len,
  input  logic [IDX_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic             act_stb,
  output logic [W-1:0]     sq_c1,
  output logic [W-1:0]     sq_x,
  output logic [IDX_W-1:0] sq_i,
  output logic [W-1:0]     sq_act
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [W-1:0]     ONE       = W'(1);
  localparam logic [IDX_W-1:0] I_ONE     = IDX_W'(1);
  // An offset outside the counter range can never match, so the strobe is disabled.
  localparam bit               TRIG_FITS = (TRIG_AT >= 0) && (TRIG_AT < (2 ** W));
  localparam logic [W-1:0]     TRIG_V    = TRIG_FITS ? W'(TRIG_AT) : '0;

  state_t           state_q, state_d;
  logic [W-1:0]     len_q, len_d;
  logic [IDX_W-1:0] steps_q, steps_d;
  logic [W-1:0]     c1_q, c1_d;
  logic [W-1:0]     x_q, x_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [W-1:0]     act_q, act_d;
  logic             stb_q, stb_d;
  logic             done_q, done_d;

  logic [W-1:0] len_eff;
  logic         step_end;
  logic         last_end;

  always_comb begin
    len_eff  = (len == '0) ? ONE : len;
    step_end = (c1_q == (len_q - ONE));
    last_end = step_end && (i_q == steps_q);

    state_d = state_q;
    len_d   = len_q;
    steps_d = steps_q;
    c1_d    = c1_q;
    x_d     = x_q;
    i_d     = i_q;
    act_d   = act_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          len_d   = len_eff;
          steps_d = steps;
          c1_d    = '0;
          x_d     = '0;
          i_d     = '0;
          act_d   = '0;
        end
      end
      S_RUN: begin
        x_d = x_q + ONE;
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          stb_d = TRIG_FITS && (c1_q == TRIG_V);
          if (stb_d && (act_q != '1)) begin
            act_d = act_q + ONE;
          end
          if (last_end) begin
            done_d = 1'b1;
            if (AUTO_RESTART != 0) begin
              c1_d    = '0;
              i_d     = '0;
              x_d     = '0;
              len_d   = len_eff;
              steps_d = steps;
            end else begin
              // Tick and step index keep their final values for inspection.
              state_d = S_IDLE;
            end
          end else if (step_end) begin
            c1_d = '0;
            i_d  = i_q + I_ONE;
          end else begin
            c1_d = c1_q + ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= ONE;
      steps_q <= '0;
      c1_q    <= '0;
      x_q     <= '0;
      i_q     <= '0;
      act_q   <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      steps_q <= steps_d;
      c1_q    <= c1_d;
      x_q     <= x_d;
      i_q     <= i_d;
      act_q   <= act_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = done_q;
  assign act_stb = stb_q;
  assign sq_c1   = c1_q;
  assign sq_x    = x_q;
  assign sq_i    = i_q;
  assign sq_act  = act_q;

endmodule

// File: tb/tb_timed_step_seq.sv
// Bench for timed_step_seq: three instances (trigger 0, trigger 5, auto-restart) share stimulus;
// expected outputs are derived arithmetically from the run-cycle index.
module tb_timed_step_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, stop;
  logic [7:0] len;
  logic [1:0] steps;

  logic       busy0, done0, stb0, busy1, done1, stb1, busy2, done2, stb2;
  logic [7:0] c10, x0, act0, c11, x1, act1, c12, x2, act2;
  logic [1:0] i0, i1, i2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timed_step_seq #(.W(8), .IDX_W(2), .TRIG_AT(0), .AUTO_RESTART(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .len(len), .steps(steps),
    .busy(busy0), .done(done0), .act_stb(stb0), .sq_c1(c10), .sq_x(x0), .sq_i(i0), .sq_act(act0));

  timed_step_seq #(.W(8), .IDX_W(2), .TRIG_AT(5), .AUTO_RESTART(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .len(len), .steps(steps),
    .busy(busy1), .done(done1), .act_stb(stb1), .sq_c1(c11), .sq_x(x1), .sq_i(i1), .sq_act(act1));

  timed_step_seq #(.W(8), .IDX_W(2), .TRIG_AT(2), .AUTO_RESTART(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .len(len), .steps(steps),
    .busy(busy2), .done(done2), .act_stb(stb2), .sq_c1(c12), .sq_x(x2), .sq_i(i2), .sq_act(act2));

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; len = 8'd0; steps = 2'd0;
    #1;
    checks++; if ({busy0, done0, stb0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy0, done0, stb0}); end
    checks++; if ({c10, x0, i0, act0} !== 26'd0) begin errors++; $display("FAIL reset_counters got %h exp 0", {c10, x0, i0, act0}); end
    checks++; if ({busy2, c12, act2} !== 17'd0) begin errors++; $display("FAIL reset_auto got %h exp 0", {busy2, c12, act2}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b exp 0", busy0); end
  endtask

  // One complete run on dut0/dut1; jitter adds ignored start pulses and len/steps changes.
  task automatic run_check(input int l, input int s, input bit jitter);
    int le, n_tot, a0, a1, e_c1, e_i, e_x;
    bit run, e_done, e_stb0, e_stb1;
    le = (l == 0) ? 1 : l;
    n_tot = (s + 1) * le;
    a0 = 0; a1 = 0;
    @(negedge clk);
    start = 1'b1; stop = 1'b0; len = 8'(l); steps = 2'(s);
    for (int n = 0; n <= n_tot + 2; n++) begin
      @(negedge clk);
      start = (jitter && n < n_tot) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (jitter) begin len = 8'($urandom); steps = 2'($urandom); end
      run    = (n < n_tot);
      e_done = (n == n_tot);
      e_c1   = run ? n % le : le - 1;
      e_i    = run ? n / le : s;
      e_x    = (run ? n : n_tot) % 256;
      e_stb0 = (n >= 1) && (n <= n_tot) && (((n - 1) % le) == 0);
      e_stb1 = (n >= 1) && (n <= n_tot) && (((n - 1) % le) == 5);
      a0 += int'(e_stb0);
      a1 += int'(e_stb1);
      checks++; if (busy0 !== run) begin errors++; $display("FAIL busy l=%0d s=%0d n=%0d got %b exp %b", l, s, n, busy0, run); end
      checks++; if (done0 !== e_done) begin errors++; $display("FAIL done l=%0d s=%0d n=%0d got %b exp %b", l, s, n, done0, e_done); end
      checks++; if (c10 !== 8'(e_c1)) begin errors++; $display("FAIL sq_c1 l=%0d s=%0d n=%0d got %0d exp %0d", l, s, n, c10, e_c1); end
      checks++; if (i0 !== 2'(e_i)) begin errors++; $display("FAIL sq_i l=%0d s=%0d n=%0d got %0d exp %0d", l, s, n, i0, e_i); end
      checks++; if (x0 !== 8'(e_x)) begin errors++; $display("FAIL sq_x l=%0d s=%0d n=%0d got %0d exp %0d", l, s, n, x0, e_x); end
      checks++; if (stb0 !== e_stb0) begin errors++; $display("FAIL act_stb_t0 l=%0d s=%0d n=%0d got %b exp %b", l, s, n, stb0, e_stb0); end
      checks++; if (act0 !== 8'(a0)) begin errors++; $display("FAIL sq_act_t0 l=%0d s=%0d n=%0d got %0d exp %0d", l, s, n, act0, a0); end
      checks++; if (stb1 !== e_stb1) begin errors++; $display("FAIL act_stb_t5 l=%0d s=%0d n=%0d got %b exp %b", l, s, n, stb1, e_stb1); end
      checks++; if (act1 !== 8'(a1)) begin errors++; $display("FAIL sq_act_t5 l=%0d s=%0d n=%0d got %0d exp %0d", l, s, n, act1, a1); end
    end
  endtask

  task automatic test_runs();
    run_check(10, 1, 1'b0);
    run_check(0, 0, 1'b0);
    run_check(4, 3, 1'b0);
    run_check(200, 3, 1'b0);
    for (int k = 0; k < 6; k++) run_check(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'b1);
  endtask

  task automatic test_stop();
    @(negedge clk);
    start = 1'b1; stop = 1'b0; len = 8'd10; steps = 2'd1;
    for (int n = 0; n <= 7; n++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = (n == 7);
    end
    @(negedge clk);
    // stop still high together with start: must not launch a run from IDLE
    start = 1'b1;
    checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL stop_busy_done got %b exp 00", {busy0, done0}); end
    checks++; if ({c10, x0, i0} !== {8'd7, 8'd8, 2'd0}) begin errors++; $display("FAIL stop_counters c1=%0d x=%0d i=%0d exp 7 8 0", c10, x0, i0); end
    checks++; if (act0 !== 8'd1) begin errors++; $display("FAIL stop_act got %0d exp 1", act0); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++; if ({busy0, done0, c10, x0} !== {2'b00, 8'd7, 8'd8}) begin errors++; $display("FAIL stop_hold busy=%b done=%b c1=%0d x=%0d", busy0, done0, c10, x0); end
    end
    start = 1'b0; stop = 1'b0;
    run_check(10, 1, 1'b0);
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start = 1'b1; stop = 1'b0; len = 8'd10; steps = 2'd3;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy0, done0, stb0, c10, x0, i0, act0} !== 29'd0) begin errors++; $display("FAIL midrun_reset got %h exp 0", {busy0, done0, stb0, c10, x0, i0, act0}); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++; if ({busy0, done0, busy2} !== 3'b000) begin errors++; $display("FAIL held_reset got %b exp 000", {busy0, done0, busy2}); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy0, c10, x0} !== {1'b1, 8'd0, 8'd0}) begin errors++; $display("FAIL restart_after_reset busy=%b c1=%0d x=%0d exp 1 0 0", busy0, c10, x0); end
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL stop_after_reset got %b exp 00", {busy0, done0}); end
  endtask

  task automatic test_auto_restart();
    int e_act;
    bit e_done;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 8'd3; steps = 2'd0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      start  = 1'b0;
      e_done = (n >= 3) && (n % 3 == 0);
      e_act  = (n / 3 > 255) ? 255 : n / 3;
      checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL ar_busy n=%0d got %b exp 1", n, busy2); end
      checks++; if (done2 !== e_done) begin errors++; $display("FAIL ar_done n=%0d got %b exp %b", n, done2, e_done); end
      checks++; if (stb2 !== e_done) begin errors++; $display("FAIL ar_stb n=%0d got %b exp %b", n, stb2, e_done); end
      checks++; if ({c12, x2, i2} !== {8'(n % 3), 8'(n % 3), 2'd0}) begin errors++; $display("FAIL ar_counters n=%0d c1=%0d x=%0d i=%0d", n, c12, x2, i2); end
      checks++; if (act2 !== 8'(e_act)) begin errors++; $display("FAIL ar_act n=%0d got %0d exp %0d", n, act2, e_act); end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if ({busy2, done2} !== 2'b00) begin errors++; $display("FAIL ar_stop got %b exp 00", {busy2, done2}); end
  endtask

  initial begin
    test_reset();
    test_runs();
    test_stop();
    test_reset_midrun();
    test_auto_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
